// File: rtl/cpu_0_oci_dct_pkg.sv
// Shared constants and FSM encoding for the OCI DCT trace-atom packer.
package cpu_0_oci_dct_pkg;

    localparam int unsigned SLOTS  = 15;
    localparam int unsigned ATOM_W = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BUF_W  = SLOTS * ATOM_W;

    typedef enum logic [1:0] {
        PACK  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } dct_state_e;

endpackage

// File: rtl/cpu_0_oci_dct_packer_if.sv
// Atom requester and packed-word handshake bundle of the DCT packer.
interface cpu_0_oci_dct_packer_if;
    import cpu_0_oci_dct_pkg::*;

    logic              it_valid;
    logic [ATOM_W-1:0] it_atom;
    logic              it_ready;
    logic              dt_valid;
    logic [ATOM_W-1:0] dt_atom;
    logic              dt_ready;
    logic              out_valid;
    logic              out_ready;
    logic [BUF_W-1:0]  out_buffer;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output it_valid, it_atom, dt_valid, dt_atom, out_ready,
        input  it_ready, dt_ready, out_valid, out_buffer, out_count
    );

    modport slave (
        input  it_valid, it_atom, dt_valid, dt_atom, out_ready,
        output it_ready, dt_ready, out_valid, out_buffer, out_count
    );

endinterface

// File: rtl/cpu_0_oci_dct_rr_arb.sv
// Two-way round-robin grant; pointer moves to the other requester after any grant.
module cpu_0_oci_dct_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic req_it_i,
    input  logic req_dt_i,
    output logic gnt_it_o,
    output logic gnt_dt_o
);

    logic ptr_dt_q, ptr_dt_d;

    always_comb begin
        gnt_it_o = en_i & req_it_i & (~req_dt_i | ~ptr_dt_q);
        gnt_dt_o = en_i & req_dt_i & (~req_it_i |  ptr_dt_q);
        ptr_dt_d = ptr_dt_q;
        if (gnt_it_o)      ptr_dt_d = 1'b1;
        else if (gnt_dt_o) ptr_dt_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_dt_q <= 1'b0;
        else       ptr_dt_q <= ptr_dt_d;
    end

endmodule

// File: rtl/cpu_0_oci_dct_packer.sv
// OCI DCT trace-atom packer: arbitrates it/dt atoms into 15x2-bit words.
// Optional CPU_0_OCI_DCT_STALL_CNT_EN adds a saturating stall_cnt output.
module cpu_0_oci_dct_packer
    import cpu_0_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    cpu_0_oci_dct_packer_if.slave bus,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [BUF_W-1:0]     dct_buffer,
    output logic [CNT_W-1:0]     dct_count
`ifdef CPU_0_OCI_DCT_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    dct_state_e        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ov_q, ov_d;
    logic [BUF_W-1:0]  ob_q, ob_d;
    logic [CNT_W-1:0]  oc_q, oc_d;
    logic              fd_q, fd_d;
    logic              accept_en, out_free, load, gnt_it, gnt_dt;
    logic [ATOM_W-1:0] atom;

    cpu_0_oci_dct_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .en_i     (accept_en),
        .req_it_i (bus.it_valid),
        .req_dt_i (bus.dt_valid),
        .gnt_it_o (gnt_it),
        .gnt_dt_o (gnt_dt)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= PACK;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PACK:    if (flush) state_d = FLUSH;
            FLUSH:   if (cnt_q == '0 || load) state_d = DONE;
            DONE:    if (!flush) state_d = PACK;
            default: state_d = PACK;
        endcase
    end

    // A word leaves when full, or whatever is left once flushing has begun.
    always_comb begin
        accept_en = ~reset & (state_q == PACK) & (cnt_q < CNT_W'(SLOTS));
        out_free  = ~ov_q | bus.out_ready;
        load      = out_free & (cnt_q != '0) &
                    ((cnt_q == CNT_W'(SLOTS)) | (state_q == FLUSH));
        fd_d      = (state_q == FLUSH) & (state_d == DONE);
    end

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        ov_d  = ov_q & ~bus.out_ready;
        ob_d  = ob_q;
        oc_d  = oc_q;
        atom  = gnt_dt ? bus.dt_atom : bus.it_atom;
        if (load) begin
            ov_d  = 1'b1;
            ob_d  = buf_q;
            oc_d  = cnt_q;
            buf_d = '0;
            cnt_d = '0;
        end else if (gnt_it | gnt_dt) begin
            for (int unsigned k = 0; k < SLOTS; k++)
                if (cnt_q == CNT_W'(k)) buf_d[k*ATOM_W +: ATOM_W] = atom;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
            ov_q  <= 1'b0;
            ob_q  <= '0;
            oc_q  <= '0;
            fd_q  <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            ov_q  <= ov_d;
            ob_q  <= ob_d;
            oc_q  <= oc_d;
            fd_q  <= fd_d;
        end
    end

    assign bus.it_ready   = gnt_it;
    assign bus.dt_ready   = gnt_dt;
    assign bus.out_valid  = ov_q;
    assign bus.out_buffer = ob_q;
    assign bus.out_count  = oc_q;
    assign flush_done     = fd_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;

`ifdef CPU_0_OCI_DCT_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((bus.it_valid | bus.dt_valid) & ~(gnt_it | gnt_dt) & (stall_q != '1))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cpu_0_oci_dct_packer.sv
// Self-checking bench for cpu_0_oci_dct_packer against a queue-based atom model.
module tb_cpu_0_oci_dct_packer;
    import cpu_0_oci_dct_pkg::*;

    localparam int M_PACK = 0, M_FLUSH = 1, M_DONE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        flush_done;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
`ifdef CPU_0_OCI_DCT_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    cpu_0_oci_dct_packer_if bus ();

    cpu_0_oci_dct_packer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count)
`ifdef CPU_0_OCI_DCT_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: atoms currently packed, in arrival order.
    logic [1:0]  m_atoms[$];
    bit          m_rr_dt;
    int          m_mode;
    bit          m_ov;
    logic [29:0] m_ob;
    int          m_oc;
    bit          m_fd;
    int          m_stall;

    // Observations of DUT traffic for directed scenarios.
    int          seen_atoms;
    int          fd_pulses;
    logic [29:0] last_word;
    int          last_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [29:0] m_buf();
        logic [29:0] r = '0;
        foreach (m_atoms[i]) r |= 30'(m_atoms[i]) << (2 * i);
        return r;
    endfunction

    // Called at a negedge: check registered state, drive inputs, check grants, advance model.
    task automatic cycle(input bit r, input bit itv, input logic [1:0] ita,
                         input bit dtv, input logic [1:0] dta, input bit fl, input bit ordy);
        bit g_it, g_dt, acc, load, ovn, fdn;
        int cnt, mode_n;
        check("out_valid",  32'(bus.out_valid),  32'(m_ov));
        check("out_buffer", 32'(bus.out_buffer), 32'(m_ob));
        check("out_count",  32'(bus.out_count),  32'(m_oc));
        check("dct_count",  32'(dct_count),      32'(m_atoms.size()));
        check("dct_buffer", 32'(dct_buffer),     32'(m_buf()));
        check("flush_done", 32'(flush_done),     32'(m_fd));
`ifdef CPU_0_OCI_DCT_STALL_CNT_EN
        check("stall_cnt",  32'(stall_cnt),      32'(m_stall));
`endif
        fd_pulses += int'(flush_done);
        if (!r && bus.out_valid && ordy) begin
            seen_atoms += int'(bus.out_count);
            last_word   = bus.out_buffer;
            last_cnt    = int'(bus.out_count);
        end

        reset = r; bus.it_valid = itv; bus.it_atom = ita;
        bus.dt_valid = dtv; bus.dt_atom = dta; flush = fl; bus.out_ready = ordy;
        #1;
        cnt  = m_atoms.size();
        acc  = !r && m_mode == M_PACK && cnt < 15;
        g_it = acc && itv && (!dtv || !m_rr_dt);
        g_dt = acc && dtv && (!itv ||  m_rr_dt);
        check("it_ready", 32'(bus.it_ready), 32'(g_it));
        check("dt_ready", 32'(bus.dt_ready), 32'(g_dt));

        if (r) begin
            m_atoms.delete(); m_rr_dt = 0; m_mode = M_PACK;
            m_ov = 0; m_ob = '0; m_oc = 0; m_fd = 0; m_stall = 0;
        end else begin
            ovn    = m_ov && !ordy;
            load   = (!m_ov || ordy) && cnt > 0 && (cnt == 15 || m_mode == M_FLUSH);
            fdn    = 0;
            mode_n = m_mode;
            if ((itv || dtv) && !(g_it || g_dt) && m_stall < 65535) m_stall++;
            case (m_mode)
                M_PACK:  if (fl) mode_n = M_FLUSH;
                M_FLUSH: if (cnt == 0 || load) begin mode_n = M_DONE; fdn = 1; end
                default: if (!fl) mode_n = M_PACK;
            endcase
            if (load) begin
                m_ob = m_buf(); m_oc = cnt; ovn = 1; m_atoms.delete();
            end else if (g_it) begin
                m_atoms.push_back(ita); m_rr_dt = 1;
            end else if (g_dt) begin
                m_atoms.push_back(dta); m_rr_dt = 0;
            end
            m_ov = ovn; m_fd = fdn; m_mode = mode_n;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 0, 2'b00, 0, 2'b00, 0, ordy);
    endtask

    task automatic do_reset();
        cycle(1, 0, 2'b00, 0, 2'b00, 0, 0);
    endtask

    bit fl_r;
    int s0;

    initial begin
        // Bring-up reset before any comparison: outputs are unknown until then.
        reset = 1; flush = 0;
        bus.it_valid = 0; bus.it_atom = '0; bus.dt_valid = 0; bus.dt_atom = '0; bus.out_ready = 0;
        m_atoms.delete(); m_rr_dt = 0; m_mode = M_PACK;
        m_ov = 0; m_ob = '0; m_oc = 0; m_fd = 0; m_stall = 0;
        seen_atoms = 0; fd_pulses = 0; last_word = '0; last_cnt = 0;
        @(posedge clk); @(negedge clk);
        do_reset();

        // 1: fifteen it atoms make one full word.
        for (int i = 0; i < 15; i++) cycle(0, 1, 2'b01, 0, 2'b00, 0, 1);
        idle(1);
        check("t1_valid", 32'(bus.out_valid),  32'd1);
        check("t1_buf",   32'(bus.out_buffer), 32'h15555555);
        check("t1_cnt",   32'(bus.out_count),  32'hF);
        check("t1_dcnt",  32'(dct_count),      32'd0);
        idle(1);
        check("t1_clear", 32'(bus.out_valid),  32'd0);

        // 2: both requesters valid alternate starting with it.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 1, 2'b01, 1, 2'b10, 0, 1);
        check("t2_buf", 32'(dct_buffer), 32'h99);
        check("t2_cnt", 32'(dct_count),  32'd4);

        // 3: back-pressure holds two words without losing atoms.
        do_reset();
        seen_atoms = 0;
        for (int i = 0; i < 34; i++) cycle(0, 1, 2'($urandom_range(0, 3)), 0, 2'b00, 0, 0);
        check("t3_held", 32'(bus.out_valid), 32'd1);
        check("t3_full", 32'(dct_count),     32'd15);
        for (int i = 0; i < 4; i++) idle(1);
        check("t3_atoms", 32'(seen_atoms), 32'd30);

        // 4: flush drains a partial word and refuses atoms until released.
        do_reset();
        fd_pulses = 0; last_word = '0; last_cnt = 0;
        for (int i = 0; i < 3; i++) cycle(0, 1, 2'b11, 0, 2'b00, 0, 1);
        cycle(0, 0, 2'b00, 0, 2'b00, 1, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 2'b01, 1, 2'b10, 1, 1);
        for (int i = 0; i < 2; i++) idle(1);
        check("t4_word",  32'(last_word), 32'h3F);
        check("t4_cnt",   32'(last_cnt),  32'd3);
        check("t4_pulse", 32'(fd_pulses), 32'd1);

        // 5: reset discards partial buffer and pending output word.
        do_reset();
        for (int i = 0; i < 23; i++) cycle(0, 1, 2'b10, 0, 2'b00, 0, 0);
        check("t5_pre_cnt", 32'(dct_count),     32'd7);
        check("t5_pre_ov",  32'(bus.out_valid), 32'd1);
        do_reset();
        check("t5_cnt", 32'(dct_count),     32'd0);
        check("t5_buf", 32'(dct_buffer),    32'd0);
        check("t5_ov",  32'(bus.out_valid), 32'd0);

`ifdef CPU_0_OCI_DCT_STALL_CNT_EN
        // 6: stall cycles counted while both word slots are full.
        do_reset();
        for (int i = 0; i < 31; i++) cycle(0, 1, 2'b01, 0, 2'b00, 0, 0);
        s0 = int'(stall_cnt);
        for (int i = 0; i < 20; i++) cycle(0, 1, 2'b01, 0, 2'b00, 0, 0);
        check("t6_stall", 32'(int'(stall_cnt) - s0), 32'd20);
`endif

        // Random traffic, occasional flush toggles and resets.
        do_reset();
        fl_r = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) fl_r = !fl_r;
            cycle($urandom_range(0, 199) == 0,
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  fl_r, $urandom_range(0, 3) != 0);
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
